// File: rtl/imem_pkg.sv
// Shared constants and types for the synchronous instruction memory.
// NOP is addi x0,x0,0; fault bits index into the 2-bit rsp_fault code.
package imem_pkg;

  localparam logic [31:0] NOP = 32'h00000013;

  localparam int FAULT_MISALIGN = 0;
  localparam int FAULT_RANGE    = 1;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

endpackage

// File: rtl/imem_ram.sv
// DEPTH x 32 RAM with one write port and one registered read port.
// A read and a write to the same word in one cycle return the old word.
module imem_ram #(
  parameter int DEPTH = 1024,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [IW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_sync.sv
// Synchronous-read instruction memory: clears itself to NOP after reset,
// then serves one-cycle-latency fetches and accepts word loads.
module imem_sync #(
  parameter int          DEPTH = 1024,
  parameter int          AW    = 32,
  parameter logic [31:0] NOP   = imem_pkg::NOP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_data,
  output logic [1:0]    rsp_fault,
  input  logic          flush,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic          init_done
);

  import imem_pkg::*;

  localparam int            IW    = $clog2(DEPTH);
  localparam logic [AW-1:0] WORDS = AW'(DEPTH);

  state_t        state;
  logic [IW-1:0] cnt;
  logic          rd_ram;
  logic [31:0]   ram_q;
  logic          accept;
  logic [1:0]    req_fault;
  logic          load_ok;
  logic          ram_we;
  logic          ram_re;
  logic [IW-1:0] ram_waddr;
  logic [31:0]   ram_wdata;

  assign req_ready = init_done && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    req_fault                 = '0;
    req_fault[FAULT_MISALIGN] = (req_addr[1:0] != 2'b00);
    req_fault[FAULT_RANGE]    = ((req_addr >> 2) >= WORDS);
  end

  assign load_ok = load_en && (load_addr[1:0] == 2'b00) && ((load_addr >> 2) < WORDS);

  // The sweep owns the write port during INIT; loads only reach it in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = cnt;
    ram_wdata = NOP;
    if (!reset) begin
      if (state == ST_INIT) begin
        ram_we = 1'b1;
      end else begin
        ram_we    = load_ok;
        ram_waddr = load_addr[IW+1:2];
        ram_wdata = load_data;
      end
    end
  end

  assign ram_re = accept && !flush && !reset && (req_fault == 2'b00);

  imem_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (req_addr[IW+1:2]),
    .rdata (ram_q)
  );

  // Faulted responses never touch the RAM; rd_ram picks NOP instead.
  assign rsp_data = rd_ram ? ram_q : NOP;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_INIT;
      cnt       <= '0;
      init_done <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_fault <= 2'b00;
      rd_ram    <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == IW'(DEPTH - 1)) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush) begin
            rsp_valid <= 1'b0;
          end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_fault <= req_fault;
            rd_ram    <= (req_fault == 2'b00);
          end else if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_sync.sv
// Scoreboard bench for imem_sync: the driver queues expected words on each
// accepted fetch, the monitor pops and compares on each consumed response.
module tb_imem_sync;

  localparam int          DEPTH = 1024;
  localparam int          AW    = 32;
  localparam logic [31:0] NOPW  = 32'h00000013;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  fault;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_data;
  logic [1:0]    rsp_fault;
  logic          flush;
  logic          load_en;
  logic [AW-1:0] load_addr;
  logic [31:0]   load_data;
  logic          init_done;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pop_last = 0;
  int   pop_prev = 0;
  int   n_init;

  imem_sync #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .NOP   (NOPW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed at the edge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && rsp_valid && rsp_ready && !flush) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_rsp: got %h with empty scoreboard", rsp_data);
      end else begin
        e = sb.pop_front();
        check_output("rsp_data", rsp_data, e.data);
        check_output("rsp_fault", {30'b0, rsp_fault}, {30'b0, e.fault});
        pop_prev = pop_last;
        pop_last = cyc;
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] fault);
    bit got = 0;
    req_valid = 1'b1;
    req_addr  = addr;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        got = 1;
        sb.push_back('{data: data, fault: fault});
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout: req_ready got 0 expected 1 (addr %h)", addr);
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic apply_load(input logic [31:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    @(posedge clk);
    #1;
    load_en = 1'b0;
  endtask

  task automatic wait_init(output int n);
    n = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (req_ready) break;
      n++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check_output("drain_empty", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b1;
    flush     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    check_output("rst_req_ready", {31'b0, req_ready}, 0);
    check_output("rst_init_done", {31'b0, init_done}, 0);
    check_output("rst_rsp_data", rsp_data, NOPW);
    check_output("rst_rsp_fault", {30'b0, rsp_fault}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    wait_init(n_init);
    check_output("init_latency", n_init, DEPTH);
    check_output("init_done", {31'b0, init_done}, 1);
    apply_stimulus(32'h0, NOPW, 2'b00);
    drain();

    // Program two words, then fetch them back-to-back.
    apply_load(32'h0, 32'h00A00293);
    apply_load(32'h1C, 32'hFFF28293);
    apply_stimulus(32'h0, 32'h00A00293, 2'b00);
    apply_stimulus(32'h1C, 32'hFFF28293, 2'b00);
    drain();
    check_output("b2b_gap", pop_last - pop_prev, 1);

    // Fault decode and dropped loads.
    apply_stimulus(32'h2, NOPW, 2'b01);
    apply_stimulus(32'h1000, NOPW, 2'b10);
    apply_stimulus(32'h1002, NOPW, 2'b11);
    apply_load(32'h1000, 32'hCAFEBABE);
    apply_load(32'h1E, 32'hBAD0BAD0);
    apply_stimulus(32'h0, 32'h00A00293, 2'b00);
    apply_stimulus(32'h1C, 32'hFFF28293, 2'b00);
    drain();

    // Backpressure: response held, no new accepts.
    rsp_ready = 1'b0;
    apply_stimulus(32'h0, 32'h00A00293, 2'b00);
    req_valid = 1'b1;
    req_addr  = 32'h1C;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_req_ready", {31'b0, req_ready}, 0);
      check_output("bp_rsp_valid", {31'b0, rsp_valid}, 1);
      check_output("bp_rsp_data", rsp_data, 32'h00A00293);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    apply_stimulus(32'h1C, 32'hFFF28293, 2'b00);
    drain();

    // Read-first on a same-cycle load and fetch.
    apply_load(32'h40, 32'hDEADBEEF);
    load_en   = 1'b1;
    load_addr = 32'h40;
    load_data = 32'h12345678;
    apply_stimulus(32'h40, 32'hDEADBEEF, 2'b00);
    load_en = 1'b0;
    apply_stimulus(32'h40, 32'h12345678, 2'b00);
    drain();

    // Flush discards a pending response.
    rsp_ready = 1'b0;
    apply_stimulus(32'h1C, 32'hFFF28293, 2'b00);
    flush = 1'b1;
    @(negedge clk);
    check_output("flush_pre_valid", {31'b0, rsp_valid}, 1);
    @(posedge clk);
    #1;
    flush = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    check_output("flush_rsp_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;

    // Reset in RUN wipes the program back to NOP.
    reset = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("rerst_init_done", {31'b0, init_done}, 0);
    check_output("rerst_req_ready", {31'b0, req_ready}, 0);
    check_output("rerst_rsp_valid", {31'b0, rsp_valid}, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_init(n_init);
    check_output("reinit_latency", n_init, DEPTH);
    apply_stimulus(32'h0, NOPW, 2'b00);
    apply_stimulus(32'h1C, NOPW, 2'b00);
    apply_stimulus(32'h40, NOPW, 2'b00);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
